// File: rtl/ddr3_mem_resp.sv
// DDR3 device-side responder: decodes commands, tracks open rows per bank,
// stores 4-beat x16 write bursts and replays them as 4-beat read bursts.
module ddr3_mem_resp #(
  parameter int ROW_W = 2,
  parameter int COL_W = 3
) (
  input  logic        cpu_clk,
  input  logic        reset_n,
  input  logic        cke,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [2:0]  ba,
  input  logic [14:0] addr,
  input  logic [9:0]  col,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        cmd_err,
  output logic [7:0]  bank_open,
  output logic        zq_cal_done
);

  localparam int IDX_W = 3 + ROW_W + COL_W;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  state_t             state;
  logic [1:0]         beat_cnt;
  logic [IDX_W-1:0]   burst_idx;
  logic [ROW_W-1:0]   open_row [8];
  logic [63:0]        mem [DEPTH];

  logic [3:0]         cmd;
  logic               is_nop, is_act, is_pre, is_wr, is_rd, is_zqc;
  logic               busy;
  logic               mem_we;
  logic [IDX_W-1:0]   acc_idx;
  logic               unused_bits;

  assign cmd    = {cs_n, ras_n, cas_n, we_n};
  assign is_nop = cs_n || (cmd == 4'b0111);
  assign is_act = (cmd == 4'b0011);
  assign is_pre = (cmd == 4'b0010);
  assign is_wr  = (cmd == 4'b0100);
  assign is_rd  = (cmd == 4'b0101);
  assign is_zqc = (cmd == 4'b0110);

  // The final write beat edge is not busy: a new command is accepted alongside it.
  assign busy    = (state == S_RD) || ((state == S_WR) && (beat_cnt != 2'd3));
  assign mem_we  = cke && (state == S_WR);
  assign acc_idx = {ba, open_row[ba], col[COL_W-1:0]};

  assign unused_bits = ^{addr[14:11], addr[9:ROW_W], col[9:COL_W]};

  // Array is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge cpu_clk) begin
    if (mem_we) begin
      mem[burst_idx][{beat_cnt, 4'b0000} +: 16] <= wr_data;
    end
  end

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      beat_cnt    <= 2'd0;
      burst_idx   <= '0;
      rd_data     <= 16'h0000;
      rd_valid    <= 1'b0;
      cmd_err     <= 1'b0;
      bank_open   <= 8'h00;
      zq_cal_done <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        open_row[i] <= '0;
      end
    end else begin
      cmd_err  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= 16'h0000;
      if (cke) begin
        // Burst progression first so an accepted command can override state.
        if (state == S_RD) begin
          rd_valid <= 1'b1;
          rd_data  <= mem[burst_idx][{beat_cnt, 4'b0000} +: 16];
          beat_cnt <= beat_cnt + 2'd1;
          if (beat_cnt == 2'd3) state <= S_IDLE;
        end else if (state == S_WR) begin
          beat_cnt <= beat_cnt + 2'd1;
          if (beat_cnt == 2'd3) state <= S_IDLE;
        end

        if (busy) begin
          if (!is_nop) cmd_err <= 1'b1;
        end else if (is_nop) begin
          cmd_err <= 1'b0;
        end else if (is_act) begin
          if (bank_open[ba] || !zq_cal_done) begin
            cmd_err <= 1'b1;
          end else begin
            bank_open[ba] <= 1'b1;
            open_row[ba]  <= addr[ROW_W-1:0];
          end
        end else if (is_pre) begin
          if (addr[10]) bank_open <= 8'h00;
          else          bank_open[ba] <= 1'b0;
        end else if (is_rd) begin
          if (!bank_open[ba]) begin
            cmd_err <= 1'b1;
          end else begin
            state     <= S_RD;
            burst_idx <= acc_idx;
            beat_cnt  <= 2'd1;
            rd_valid  <= 1'b1;
            rd_data   <= mem[acc_idx][15:0];
          end
        end else if (is_wr) begin
          if (!bank_open[ba]) begin
            cmd_err <= 1'b1;
          end else begin
            state     <= S_WR;
            burst_idx <= acc_idx;
            beat_cnt  <= 2'd0;
          end
        end else if (is_zqc) begin
          if (|bank_open) cmd_err <= 1'b1;
          else            zq_cal_done <= 1'b1;
        end else begin
          cmd_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr3_mem_resp.sv
// Directed bench for ddr3_mem_resp: command legality, burst data, forwarding,
// cke stall and reset-during-burst behaviour, checked with immediate assertions.
module tb_ddr3_mem_resp;

  logic        cpu_clk;
  logic        reset_n;
  logic        cke;
  logic        cs_n, ras_n, cas_n, we_n;
  logic [2:0]  ba;
  logic [14:0] addr;
  logic [9:0]  col;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        cmd_err;
  logic [7:0]  bank_open;
  logic        zq_cal_done;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_ZQC = 4'b0110;
  localparam logic [3:0] C_BAD = 4'b0000;

  ddr3_mem_resp #(.ROW_W(2), .COL_W(3)) dut (
    .cpu_clk     (cpu_clk),
    .reset_n     (reset_n),
    .cke         (cke),
    .cs_n        (cs_n),
    .ras_n       (ras_n),
    .cas_n       (cas_n),
    .we_n        (we_n),
    .ba          (ba),
    .addr        (addr),
    .col         (col),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .cmd_err     (cmd_err),
    .bank_open   (bank_open),
    .zq_cal_done (zq_cal_done)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [2:0] b, input logic [14:0] a,
                       input logic [9:0] cl, input logic [15:0] wd);
    {cs_n, ras_n, cas_n, we_n} = c;
    ba      = b;
    addr    = a;
    col     = cl;
    wr_data = wd;
  endtask

  task automatic tick;
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic chk_rd(input string tag, input logic v, input logic [15:0] d, input logic e);
    chk({tag, "_valid"}, {31'd0, rd_valid}, {31'd0, v});
    chk({tag, "_data"},  {16'd0, rd_data},  {16'd0, d});
    chk({tag, "_err"},   {31'd0, cmd_err},  {31'd0, e});
  endtask

  initial begin
    reset_n = 1'b0;
    cke     = 1'b1;
    drive(C_NOP, 3'd0, 15'd0, 10'd0, 16'h0000);
    tick;
    chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
    chk("rst_bank_open", {24'd0, bank_open}, 32'd0);
    chk("rst_zq", {31'd0, zq_cal_done}, 32'd0);
    reset_n = 1'b1;
    tick;

    // ACT before any ZQC is illegal
    drive(C_ACT, 3'd2, 15'd5, 10'd0, 16'h0000);
    tick;
    chk("act_nozq_err", {31'd0, cmd_err}, 32'd1);
    chk("act_nozq_open", {24'd0, bank_open}, 32'h00);
    drive(C_NOP, 3'd0, 15'd0, 10'd0, 16'h0000);
    tick;
    chk("act_nozq_pulse", {31'd0, cmd_err}, 32'd0);

    drive(C_ZQC, 3'd0, 15'd0, 10'd0, 16'h0000);
    tick;
    chk("zqc_done", {31'd0, zq_cal_done}, 32'd1);
    chk("zqc_err", {31'd0, cmd_err}, 32'd0);
    drive(C_ACT, 3'd2, 15'd5, 10'd0, 16'h0000);
    tick;
    chk("act2_open", {24'd0, bank_open}, 32'h04);
    chk("act2_err", {31'd0, cmd_err}, 32'd0);

    // ZQC with a bank open is illegal
    drive(C_ZQC, 3'd0, 15'd0, 10'd0, 16'h0000);
    tick;
    chk("zqc_open_err", {31'd0, cmd_err}, 32'd1);
    chk("zqc_open_zq", {31'd0, zq_cal_done}, 32'd1);
    chk("zqc_open_banks", {24'd0, bank_open}, 32'h04);
    drive(C_NOP, 3'd0, 15'd0, 10'd0, 16'h0000);
    tick;
    chk("zqc_open_pulse", {31'd0, cmd_err}, 32'd0);

    // Plain write burst then read it back
    drive(C_WR, 3'd2, 15'd0, 10'd3, 16'h0000);
    tick;
    chk("wr_err", {31'd0, cmd_err}, 32'd0);
    drive(C_NOP, 3'd0, 15'd0, 10'd0, 16'h1111); tick;
    drive(C_NOP, 3'd0, 15'd0, 10'd0, 16'h2222); tick;
    drive(C_NOP, 3'd0, 15'd0, 10'd0, 16'h3333); tick;
    drive(C_NOP, 3'd0, 15'd0, 10'd0, 16'h4444); tick;
    drive(C_NOP, 3'd0, 15'd0, 10'd0, 16'h0000); tick;
    drive(C_RD, 3'd2, 15'd0, 10'd3, 16'h0000);
    tick; chk_rd("rd_b0", 1'b1, 16'h1111, 1'b0);
    drive(C_NOP, 3'd0, 15'd0, 10'd0, 16'h0000);
    tick; chk_rd("rd_b1", 1'b1, 16'h2222, 1'b0);
    tick; chk_rd("rd_b2", 1'b1, 16'h3333, 1'b0);
    tick; chk_rd("rd_b3", 1'b1, 16'h4444, 1'b0);
    tick; chk_rd("rd_end", 1'b0, 16'h0000, 1'b0);

    // RD accepted on the beat-3 write edge sees the freshly written data
    drive(C_WR, 3'd2, 15'd0, 10'd3, 16'h0000); tick;
    drive(C_NOP, 3'd0, 15'd0, 10'd0, 16'hAAAA); tick;
    drive(C_NOP, 3'd0, 15'd0, 10'd0, 16'hBBBB); tick;
    drive(C_NOP, 3'd0, 15'd0, 10'd0, 16'hCCCC); tick;
    drive(C_RD, 3'd2, 15'd0, 10'd3, 16'hDDDD);
    tick; chk_rd("fwd_b0", 1'b1, 16'hAAAA, 1'b0);
    drive(C_NOP, 3'd0, 15'd0, 10'd0, 16'h0000);
    tick; chk_rd("fwd_b1", 1'b1, 16'hBBBB, 1'b0);
    tick; chk_rd("fwd_b2", 1'b1, 16'hCCCC, 1'b0);
    tick; chk_rd("fwd_b3", 1'b1, 16'hDDDD, 1'b0);
    tick; chk_rd("fwd_end", 1'b0, 16'h0000, 1'b0);

    // Illegal commands: closed bank, busy edge, bad encoding
    drive(C_RD, 3'd5, 15'd0, 10'd3, 16'h0000);
    tick; chk_rd("rd_closed", 1'b0, 16'h0000, 1'b1);
    drive(C_RD, 3'd2, 15'd0, 10'd3, 16'h0000);
    tick; chk_rd("ill_b0", 1'b1, 16'hAAAA, 1'b0);
    drive(C_RD, 3'd2, 15'd0, 10'd0, 16'h0000);
    tick; chk_rd("ill_busy_b1", 1'b1, 16'hBBBB, 1'b1);
    drive(C_BAD, 3'd2, 15'd0, 10'd0, 16'h0000);
    tick; chk_rd("ill_bad_b2", 1'b1, 16'hCCCC, 1'b1);
    drive(C_NOP, 3'd0, 15'd0, 10'd0, 16'h0000);
    tick; chk_rd("ill_b3", 1'b1, 16'hDDDD, 1'b0);
    tick; chk_rd("ill_end", 1'b0, 16'h0000, 1'b0);

    // cke low stalls the burst and suppresses command decode
    drive(C_RD, 3'd2, 15'd0, 10'd3, 16'h0000);
    tick; chk_rd("cke_b0", 1'b1, 16'hAAAA, 1'b0);
    cke = 1'b0;
    drive(C_BAD, 3'd0, 15'd0, 10'd0, 16'h0000);
    tick; chk_rd("cke_stall", 1'b0, 16'h0000, 1'b0);
    cke = 1'b1;
    drive(C_NOP, 3'd0, 15'd0, 10'd0, 16'h0000);
    tick; chk_rd("cke_b1", 1'b1, 16'hBBBB, 1'b0);
    tick; chk_rd("cke_b2", 1'b1, 16'hCCCC, 1'b0);
    tick; chk_rd("cke_b3", 1'b1, 16'hDDDD, 1'b0);
    tick; chk_rd("cke_end", 1'b0, 16'h0000, 1'b0);

    // Precharge single bank, then all banks
    drive(C_ACT, 3'd0, 15'd0, 10'd0, 16'h0000); tick;
    drive(C_ACT, 3'd7, 15'd3, 10'd0, 16'h0000); tick;
    chk("three_open", {24'd0, bank_open}, 32'h85);
    drive(C_PRE, 3'd7, 15'd0, 10'd0, 16'h0000); tick;
    chk("pre_one", {24'd0, bank_open}, 32'h05);
    drive(C_PRE, 3'd7, 15'd0, 10'd0, 16'h0000); tick;
    chk("pre_closed_err", {31'd0, cmd_err}, 32'd0);
    drive(C_ACT, 3'd7, 15'd3, 10'd0, 16'h0000); tick;
    drive(C_PRE, 3'd0, 15'h0400, 10'd0, 16'h0000); tick;
    chk("pre_all", {24'd0, bank_open}, 32'h00);

    // Reset during read beat 1
    drive(C_ACT, 3'd2, 15'd5, 10'd0, 16'h0000); tick;
    drive(C_RD, 3'd2, 15'd0, 10'd3, 16'h0000);
    tick; chk_rd("rst_mid_b0", 1'b1, 16'hAAAA, 1'b0);
    drive(C_NOP, 3'd0, 15'd0, 10'd0, 16'h0000);
    tick; chk_rd("rst_mid_b1", 1'b1, 16'hBBBB, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_mid_data", {16'd0, rd_data}, 32'd0);
    chk("rst_mid_open", {24'd0, bank_open}, 32'd0);
    chk("rst_mid_zq", {31'd0, zq_cal_done}, 32'd0);
    tick;
    reset_n = 1'b1;
    tick;
    drive(C_ZQC, 3'd0, 15'd0, 10'd0, 16'h0000); tick;
    drive(C_ACT, 3'd2, 15'd5, 10'd0, 16'h0000); tick;
    drive(C_RD, 3'd2, 15'd0, 10'd3, 16'h0000);
    tick; chk_rd("keep_b0", 1'b1, 16'hAAAA, 1'b0);
    drive(C_NOP, 3'd0, 15'd0, 10'd0, 16'h0000);
    tick; chk_rd("keep_b1", 1'b1, 16'hBBBB, 1'b0);
    tick; chk_rd("keep_b2", 1'b1, 16'hCCCC, 1'b0);
    tick; chk_rd("keep_b3", 1'b1, 16'hDDDD, 1'b0);
    tick; chk_rd("keep_end", 1'b0, 16'h0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
